// File: rtl/rename_pkg.sv
// Shared types and sizing constants for the register rename stage.
package rename_pkg;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;

  typedef logic [5:0] phys_reg_t;
  typedef logic [4:0] arch_reg_t;
endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical tags; resets holding ARCH_REGS..PHYS_REGS-1 in order.
module free_list
  import rename_pkg::*;
#(
  parameter int ARCH_REGS = rename_pkg::ARCH_REGS,
  parameter int PHYS_REGS = rename_pkg::PHYS_REGS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  phys_reg_t                    push_tag,
  input  logic                         pop,
  output phys_reg_t                    head_tag,
  output logic [$clog2(PHYS_REGS):0]   count
);
  localparam int PW = $clog2(PHYS_REGS);
  localparam logic [PW:0] FULL = (PW + 1)'(PHYS_REGS);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  phys_reg_t     mem [PHYS_REGS];
  logic          full;
  logic          push_ok;

  assign full     = (count == FULL);
  assign push_ok  = push && !full;
  assign head_tag = mem[head];

  // Storage, pointers and occupancy; pointers wrap naturally at PHYS_REGS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        mem[i] <= (i < PHYS_REGS - ARCH_REGS) ? phys_reg_t'(i + ARCH_REGS) : '0;
      end
      head  <= '0;
      tail  <= PW'(PHYS_REGS - ARCH_REGS);
      count <= (PW + 1)'(PHYS_REGS - ARCH_REGS);
    end else begin
      if (push_ok) begin
        mem[tail] <= push_tag;
        tail      <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  free_list_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .full (full)
  );
endmodule

// File: rtl/free_list_chk.sv
// Simulation-only checks on the free list: a push into a full list is dropped.
module free_list_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full
);
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/reg_rename.sv
// Rename stage: arch->phys map table, free-list allocation and a registered output slot.
// Optional RENAME_FREE_BYPASS_EN lets a freed tag feed an allocation directly when the list is empty.
module reg_rename
  import rename_pkg::*;
#(
  parameter int ARCH_REGS = rename_pkg::ARCH_REGS,
  parameter int PHYS_REGS = rename_pkg::PHYS_REGS
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_valid,
  output logic      o_ready,
  input  logic      i_uses_rs,
  input  logic      i_uses_rt,
  input  logic      i_uses_rw,
  input  arch_reg_t i_rs_addr,
  input  arch_reg_t i_rt_addr,
  input  arch_reg_t i_rw_addr,
  output logic      o_valid,
  input  logic      i_out_ready,
  output logic      o_uses_rs,
  output logic      o_uses_rt,
  output logic      o_uses_rw,
  output phys_reg_t o_rs_phys,
  output phys_reg_t o_rt_phys,
  output phys_reg_t o_rw_phys,
  output phys_reg_t o_old_rw_phys,
  input  logic      i_free_valid,
  input  phys_reg_t i_free_phys,
  output logic [6:0] o_free_count
);
  phys_reg_t map [ARCH_REGS];
  phys_reg_t head_tag;
  phys_reg_t new_tag;
  logic      free_ok;
  logic      bypass;
  logic      accept;
  logic      alloc;
  logic      push;
  logic      pop;

  assign free_ok = i_free_valid && (i_free_phys != 6'd0);
`ifdef RENAME_FREE_BYPASS_EN
  assign bypass = (o_free_count == 7'd0) && free_ok;
`else
  assign bypass = 1'b0;
`endif

  assign o_ready = (!o_valid || i_out_ready) && ((o_free_count != 7'd0) || bypass);
  assign accept  = i_valid && o_ready;
  assign alloc   = accept && i_uses_rw && (i_rw_addr != 5'd0);
  assign new_tag = bypass ? i_free_phys : head_tag;
  assign pop     = alloc && !bypass;
  assign push    = free_ok && !(alloc && bypass);

  free_list #(
    .ARCH_REGS (ARCH_REGS),
    .PHYS_REGS (PHYS_REGS)
  ) u_free_list (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_tag (i_free_phys),
    .pop      (pop),
    .head_tag (head_tag),
    .count    (o_free_count)
  );

  // Map table update and output slot; sources read the map before this instruction's own write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map[i] <= phys_reg_t'(i);
      end
      o_valid       <= 1'b0;
      o_uses_rs     <= 1'b0;
      o_uses_rt     <= 1'b0;
      o_uses_rw     <= 1'b0;
      o_rs_phys     <= '0;
      o_rt_phys     <= '0;
      o_rw_phys     <= '0;
      o_old_rw_phys <= '0;
    end else if (accept) begin
      o_valid       <= 1'b1;
      o_uses_rs     <= i_uses_rs;
      o_uses_rt     <= i_uses_rt;
      o_uses_rw     <= i_uses_rw;
      o_rs_phys     <= i_uses_rs ? map[i_rs_addr] : 6'd0;
      o_rt_phys     <= i_uses_rt ? map[i_rt_addr] : 6'd0;
      o_rw_phys     <= alloc ? new_tag : 6'd0;
      o_old_rw_phys <= alloc ? map[i_rw_addr] : 6'd0;
      if (alloc) begin
        map[i_rw_addr] <= new_tag;
      end
    end else if (i_out_ready) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_reg_rename.sv
// Self-checking bench for reg_rename: directed test-plan steps plus random traffic vs a queue-based model.
module tb_reg_rename;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0, o_ready;
  logic       i_uses_rs = 1'b0, i_uses_rt = 1'b0, i_uses_rw = 1'b0;
  logic [4:0] i_rs_addr = 5'd0, i_rt_addr = 5'd0, i_rw_addr = 5'd0;
  logic       o_valid, i_out_ready = 1'b0;
  logic       o_uses_rs, o_uses_rt, o_uses_rw;
  logic [5:0] o_rs_phys, o_rt_phys, o_rw_phys, o_old_rw_phys;
  logic       i_free_valid = 1'b0;
  logic [5:0] i_free_phys = 6'd0;
  logic [6:0] o_free_count;

  int total = 0;
  int bad = 0;

  // reference model state
  int m_map [32];
  int m_free [$];
  bit m_valid;
  int m_uses, m_rs, m_rt, m_rw, m_old;

  always #5 clk = ~clk;

  reg_rename dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_uses_rs(i_uses_rs), .i_uses_rt(i_uses_rt), .i_uses_rw(i_uses_rw),
    .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr), .i_rw_addr(i_rw_addr),
    .o_valid(o_valid), .i_out_ready(i_out_ready),
    .o_uses_rs(o_uses_rs), .o_uses_rt(o_uses_rt), .o_uses_rw(o_uses_rw),
    .o_rs_phys(o_rs_phys), .o_rt_phys(o_rt_phys), .o_rw_phys(o_rw_phys),
    .o_old_rw_phys(o_old_rw_phys), .i_free_valid(i_free_valid),
    .i_free_phys(i_free_phys), .o_free_count(o_free_count)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_map[i] = i;
    m_free.delete();
    for (int i = 32; i < 64; i++) m_free.push_back(i);
    m_valid = 0; m_uses = 0; m_rs = 0; m_rt = 0; m_rw = 0; m_old = 0;
  endtask

  task automatic check_outputs();
    chk("o_valid", int'(o_valid), int'(m_valid));
    chk("o_uses", int'({o_uses_rs, o_uses_rt, o_uses_rw}), m_uses);
    chk("rs_phys", int'(o_rs_phys), m_rs);
    chk("rt_phys", int'(o_rt_phys), m_rt);
    chk("rw_phys", int'(o_rw_phys), m_rw);
    chk("old_rw_phys", int'(o_old_rw_phys), m_old);
    chk("free_count", int'(o_free_count), m_free.size());
  endtask

  // One clock: drive, check ready, advance the model, then check registered outputs.
  task automatic step(input bit v, input bit urs, input bit urt, input bit urw,
                      input int rs, input int rt, input int rw,
                      input bit ordy, input bit fv, input int fp);
    bit free_ok, bypass_ok, rdy, acc, was_full;
    i_valid = v; i_uses_rs = urs; i_uses_rt = urt; i_uses_rw = urw;
    i_rs_addr = 5'(rs); i_rt_addr = 5'(rt); i_rw_addr = 5'(rw);
    i_out_ready = ordy; i_free_valid = fv; i_free_phys = 6'(fp);
    #1;
    free_ok = fv && (fp != 0);
    bypass_ok = 0;
`ifdef RENAME_FREE_BYPASS_EN
    bypass_ok = (m_free.size() == 0) && free_ok;
`endif
    rdy = (!m_valid || ordy) && (m_free.size() != 0 || bypass_ok);
    chk("o_ready", int'(o_ready), int'(rdy));
    acc = v && rdy;
    was_full = (m_free.size() == 64);
    if (acc) begin
      m_valid = 1;
      m_uses = {urs, urt, urw};
      m_rs = urs ? m_map[rs] : 0;
      m_rt = urt ? m_map[rt] : 0;
      if (urw && rw != 0) begin
        if (m_free.size() != 0) m_rw = m_free.pop_front();
        else begin m_rw = fp; free_ok = 0; end
        m_old = m_map[rw];
        m_map[rw] = m_rw;
      end else begin
        m_rw = 0; m_old = 0;
      end
    end else if (ordy) begin
      m_valid = 0;
    end
    if (free_ok && !was_full) m_free.push_back(fp);
    @(posedge clk); #1;
    check_outputs();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_outputs();
    chk("reset_ready", int'(o_ready), 1);

    // addu rs=1 rt=2 rw=3
    step(1, 1, 1, 1, 1, 2, 3, 1, 0, 0);
    chk("addu_rw", int'(o_rw_phys), 32);
    chk("addu_old", int'(o_old_rw_phys), 3);
    chk("addu_cnt", int'(o_free_count), 31);

    // back-to-back dependency on rw=3
    step(1, 0, 0, 1, 0, 0, 3, 1, 0, 0);
    step(1, 1, 0, 1, 3, 0, 3, 1, 0, 0);
    chk("b2b_rs", int'(o_rs_phys), 33);

    // no allocation: rw=0, then uses_rw=0
    step(1, 1, 1, 1, 4, 5, 0, 1, 0, 0);
    step(1, 1, 0, 0, 6, 0, 7, 1, 0, 0);
    chk("noalloc_rw", int'(o_rw_phys), 0);

    // simultaneous pop and push of 40
    step(1, 0, 0, 1, 0, 0, 8, 1, 1, 40);
    chk("popush_tail", m_free[m_free.size() - 1], 40);

    // stall output for 3 cycles with a pending instruction
    for (int k = 0; k < 3; k++) step(1, 1, 1, 1, 9, 10, 11, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // drain the free list
    for (int k = 0; k < 80 && m_free.size() != 0; k++)
      step(1, 1, 0, 1, k % 32, 0, 1 + (k % 31), 1, 0, 0);
    step(1, 0, 0, 1, 0, 0, 12, 1, 0, 0);
    chk("drained_ready", int'(o_ready), 0);
`ifdef RENAME_FREE_BYPASS_EN
    step(1, 0, 0, 1, 0, 0, 12, 1, 1, 5);
    chk("bypass_tag", int'(o_rw_phys), 5);
`else
    step(1, 0, 0, 1, 0, 0, 12, 1, 1, 5);
    step(1, 0, 0, 1, 0, 0, 12, 1, 0, 0);
    chk("freed_tag", int'(o_rw_phys), 5);
`endif

    // random traffic against the model
    for (int k = 0; k < 300; k++) begin
      bit fv;
      fv = ($urandom_range(0, 2) != 0) && (m_free.size() < 63);
      step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 3) != 0, fv, $urandom_range(0, 63));
    end

    // reset mid-stream
    step(1, 1, 1, 1, 1, 2, 3, 0, 0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_count", int'(o_free_count), 32);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1, 1, 0, 1, 3, 0, 3, 1, 0, 0);
    chk("post_rst_rw", int'(o_rw_phys), 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_rename.md
# reg_rename

Rename stage directly upstream of the physical register file. Maps each decoded instruction's architectural rs/rt/rw (5-bit) to 6-bit physical tags and allocates a fresh physical destination from a circular free list. Reports the displaced old mapping so that retire can recycle it. The register file then reads and writes purely by physical tag.

## Interface
- `ARCH_REGS`, default 32: architectural registers.
- `PHYS_REGS`, default 64: physical registers and free-list depth; power of two.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-high.
- `i_valid` in 1: decoded instruction present.
- `o_ready` out 1: stage accepts this cycle.
- `i_uses_rs`, `i_uses_rt`, `i_uses_rw` in 1 each: operand used.
- `i_rs_addr`, `i_rt_addr`, `i_rw_addr` in 5 each: architectural addresses.
- `o_valid` out 1: renamed instruction present.
- `i_out_ready` in 1: downstream accepts.
- `o_uses_rs`, `o_uses_rt`, `o_uses_rw` out 1 each: registered copies of the inputs.
- `o_rs_phys`, `o_rt_phys`, `o_rw_phys` out 6 each: physical tags.
- `o_old_rw_phys` out 6: previous mapping of rw, to be freed at retire.
- `i_free_valid` in 1: retire returns a tag.
- `i_free_phys` in 6: tag returned.
- `o_free_count` out 7: entries in the free list.

## Operation
- Reset state:
  - map[i]=i for i in 0..31.
  - Free list holds 32..63 in order; head=0, tail=32, count=32.
  - `o_valid`=0, all tag outputs 0, `o_free_count`=32.
- Accept condition: accept = `i_valid` && `o_ready`.
- Ready: `o_ready` = (!`o_valid` || `i_out_ready`) && (count != 0).
- On accept:
  - Source tags are map[rs] and map[rt], read before this instruction's own rw update, so rs==rw yields the old tag.
  - Unused sources output 0.
  - Allocation happens only when `i_uses_rw` is set and rw != 0:
    - pop the head entry into new; set `o_rw_phys`=new and `o_old_rw_phys`=map[rw]; set map[rw]=new.
  - Otherwise `o_rw_phys`=0, `o_old_rw_phys`=0, and no pop occurs.
- Output register: holds its contents while `o_valid` && !`i_out_ready`. It is cleared to `o_valid`=0 when the output is consumed and there is no accept.
- Free path: when `i_free_valid` is set and `i_free_phys` != 0, push to the tail.
  - A push while count==64 is dropped and flagged by a simulation assertion.
- Pop and push in the same cycle: count is unchanged.
- Head and tail pointers are 6-bit and wrap modulo 64. count is 7-bit and ranges 0..64.
- Architectural r0 is never remapped; map[0]=0 permanently.

## Timing
- Input to output latency is 1 cycle, registered.
- A back-to-back dependent instruction accepted on the next cycle sees the updated map, with no bubble.
- `o_free_count` reflects pushes and pops at the following edge.
- A freed tag is allocatable from the cycle after its push.
- `rst` mid-operation:
  - immediately clears `o_valid` and restores the identity map and the initial free list;
  - any in-flight free is lost.

## Configuration
- `RENAME_FREE_BYPASS_EN` defined:
  - When count==0 and `i_free_valid`, `o_ready` may be 1, and the freed tag is allocated directly to the accepting instruction without entering the list. count stays 0.
  - This path adds a combinational `i_free_valid` to `o_ready` dependency.
- `RENAME_FREE_BYPASS_EN` undefined: an empty list stalls for one extra cycle; `o_ready` never depends on `i_free_valid`.

## Structure
- Shared package `rename_pkg`:
  - `phys_reg_t` (logic [5:0]) and `arch_reg_t` (logic [4:0]);
  - constants `ARCH_REGS`, `PHYS_REGS`.
- Sub-module `free_list`: circular FIFO of `phys_reg_t` with push/pop, count, and reset contents 32..63.
- Map table and output register stay in `reg_rename`.

## Test plan
- Reset, then rename `addu` with rs=1, rt=2, rw=3 -> rs_phys=1, rt_phys=2, rw_phys=32, old_rw_phys=3, free_count=31.
- Back-to-back: rw=3 then rs=3, rw=3 -> second instruction gives rs_phys=32, rw_phys=33, old=32.
- Drain: 32 allocations with no frees -> free_count=0, `o_ready`=0.
  - Free tag 5 -> next allocation gets 5 (next cycle without the macro, same cycle with it).
- Instruction with rw=0 or `i_uses_rw`=0 -> rw_phys=0, old=0, free_count unchanged.
- Simultaneous pop and push of tag 40 -> free_count unchanged; 40 appears after the existing entries.
  - Stall `i_out_ready`=0 for 3 cycles -> outputs stable, `o_ready`=0, no pops.
- Assert `rst` mid-stream -> `o_valid`=0 at once; the first post-reset allocation returns 32.
